// File: rtl/div_issue.sv
// rtl/div_issue.sv - divide issue/complete controller between execute stage and an iterative divider
//
// Purpose: accepts DIV/DIVU from the execute stage, latches the operands for
// the divider, stalls the pipeline while the divide runs, captures the
// {remainder, quotient} result and issues a one-cycle HI/LO write strobe.
// Handles pipeline flush (annul + one-cycle ABORT) and writeback stalls.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   op_valid_i, op_is_div_i   execute-stage instruction valid / is a divide
//   op_signed_i               1 = DIV, 0 = DIVU
//   op1_i, op2_i              dividend / divisor
//   flush_i                   pipeline flush, kills an in-flight divide
//   wb_stall_i                downstream stall, holds the HI/LO write
//   div_start_o               divider start (registered, high in BUSY)
//   div_annul_o               divider annul (combinational)
//   div_signed_o, div_op1_o, div_op2_o  latched sign mode and operands
//   div_result_i, div_ready_i divider {remainder, quotient} and valid
//   stallreq_o                pipeline stall request (combinational)
//   hilo_we_o                 one-cycle HI/LO write strobe
//   hi_o, lo_o                captured remainder / quotient
//   last_lat_o                BUSY cycles of the last completed divide (sat 63)

module div_issue (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid_i,
  input  logic        op_is_div_i,
  input  logic        op_signed_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  logic        flush_i,
  input  logic        wb_stall_i,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        div_signed_o,
  output logic [31:0] div_op1_o,
  output logic [31:0] div_op2_o,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i,
  output logic        stallreq_o,
  output logic        hilo_we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [5:0]  last_lat_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_DONE  = 2'd2,
    S_ABORT = 2'd3
  } state_e;

  state_e      state_q;
  logic        start_q;
  logic        signed_q;
  logic [31:0] op1_q, op2_q;
  logic [31:0] hi_q, lo_q;
  logic [5:0]  cnt_q, cnt_d;
  logic [5:0]  last_lat_q;
  logic        accept;

  // Reset gates the combinational outputs so nothing leaks out during rst.
  assign accept = ~rst & (state_q == S_IDLE) & op_valid_i & op_is_div_i & ~flush_i;

  // Saturating BUSY-cycle count including the current cycle.
  assign cnt_d = (cnt_q == 6'd63) ? 6'd63 : cnt_q + 6'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      start_q    <= 1'b0;
      signed_q   <= 1'b0;
      op1_q      <= '0;
      op2_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      cnt_q      <= '0;
      last_lat_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op1_q    <= op1_i;
            op2_q    <= op2_i;
            signed_q <= op_signed_i;
            cnt_q    <= '0;
            start_q  <= 1'b1;
            state_q  <= S_BUSY;
          end
        end
        S_BUSY: begin
          cnt_q <= cnt_d;
          // Flush wins over a same-cycle ready: the result is discarded.
          if (flush_i) begin
            start_q <= 1'b0;
            state_q <= S_ABORT;
          end else if (div_ready_i) begin
            hi_q       <= div_result_i[63:32];
            lo_q       <= div_result_i[31:0];
            last_lat_q <= cnt_d;
            start_q    <= 1'b0;
            state_q    <= S_DONE;
          end
        end
        S_DONE: begin
          if (flush_i) begin
            state_q <= S_ABORT;
          end else if (!wb_stall_i) begin
            state_q <= S_IDLE;
          end
        end
        S_ABORT: begin
          // Guarantees the divider sees start low before any new start.
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign div_start_o  = start_q;
  assign div_signed_o = signed_q;
  assign div_op1_o    = op1_q;
  assign div_op2_o    = op2_q;
  assign hi_o         = hi_q;
  assign lo_o         = lo_q;
  assign last_lat_o   = last_lat_q;

  assign div_annul_o = ~rst & (state_q == S_BUSY) & flush_i;
  assign hilo_we_o   = ~rst & (state_q == S_DONE) & ~wb_stall_i & ~flush_i;
  assign stallreq_o  = accept | (~rst & (state_q == S_BUSY))
                     | (~rst & (state_q == S_DONE) & wb_stall_i);

endmodule

// File: tb/tb_div_issue.sv
// tb/tb_div_issue.sv - self-checking bench for div_issue with a behavioural divider model
module tb_div_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid_i, op_is_div_i, op_signed_i;
  logic [31:0] op1_i, op2_i;
  logic        flush_i, wb_stall_i;
  logic        div_start_o, div_annul_o, div_signed_o;
  logic [31:0] div_op1_o, div_op2_o;
  logic [63:0] div_result_i;
  logic        div_ready_i;
  logic        stallreq_o, hilo_we_o;
  logic [31:0] hi_o, lo_o;
  logic [5:0]  last_lat_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_hi, exp_lo;
  logic [5:0]  exp_lat;

  div_issue dut (
    .clk(clk), .rst(rst),
    .op_valid_i(op_valid_i), .op_is_div_i(op_is_div_i), .op_signed_i(op_signed_i),
    .op1_i(op1_i), .op2_i(op2_i), .flush_i(flush_i), .wb_stall_i(wb_stall_i),
    .div_start_o(div_start_o), .div_annul_o(div_annul_o), .div_signed_o(div_signed_o),
    .div_op1_o(div_op1_o), .div_op2_o(div_op2_o),
    .div_result_i(div_result_i), .div_ready_i(div_ready_i),
    .stallreq_o(stallreq_o), .hilo_we_o(hilo_we_o),
    .hi_o(hi_o), .lo_o(lo_o), .last_lat_o(last_lat_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference divider: truncating division, remainder takes the dividend's sign.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a,
                                          input logic [31:0] b, input bit zero_res);
    logic [31:0] q, r;
    if (zero_res || b == 32'd0) return 64'd0;
    if (sgn) begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_start"}, 64'(div_start_o), 64'd0);
    chk({tag, "_annul"}, 64'(div_annul_o), 64'd0);
    chk({tag, "_stall"}, 64'(stallreq_o), 64'd0);
    chk({tag, "_we"}, 64'(hilo_we_o), 64'd0);
  endtask

  // One divide transaction. Entered and left at negedge; inputs are driven
  // right after the negedge and outputs sampled 1 time unit later.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input int stall, input int flush_at,
                         input bit flush_done, input bit zero_res);
    logic [63:0] res;
    res = ref_div(sgn, a, b, zero_res);
    op_valid_i = 1'b1; op_is_div_i = 1'b1; op_signed_i = sgn; op1_i = a; op2_i = b;
    #1;
    chk("acc_stallreq", 64'(stallreq_o), 64'd1);
    chk("acc_start", 64'(div_start_o), 64'd0);
    @(negedge clk);
    op_valid_i = 1'b0; op1_i = $urandom; op2_i = $urandom; op_signed_i = ~sgn;
    for (int k = 1; k <= lat; k++) begin
      flush_i = (k == flush_at);
      if (k == lat) begin
        div_ready_i = 1'b1; div_result_i = res;
      end
      #1;
      chk("busy_start", 64'(div_start_o), 64'd1);
      chk("busy_stallreq", 64'(stallreq_o), 64'd1);
      chk("busy_op1", 64'(div_op1_o), 64'(a));
      chk("busy_op2", 64'(div_op2_o), 64'(b));
      chk("busy_signed", 64'(div_signed_o), 64'(sgn));
      chk("busy_we", 64'(hilo_we_o), 64'd0);
      chk("busy_annul", 64'(div_annul_o), 64'(k == flush_at));
      @(negedge clk);
      if (k == flush_at) begin
        flush_i = 1'b0; div_ready_i = 1'b0;
        #1;
        check_idle_outputs("abort");
        @(negedge clk);
        #1;
        check_idle_outputs("abort_idle");
        chk("abort_hi", 64'(hi_o), 64'(exp_hi));
        chk("abort_lo", 64'(lo_o), 64'(exp_lo));
        chk("abort_lat", 64'(last_lat_o), 64'(exp_lat));
        return;
      end
    end
    // Result captured on entry to DONE.
    exp_hi = res[63:32]; exp_lo = res[31:0]; exp_lat = (lat > 63) ? 6'd63 : 6'(lat);
    for (int s = 0; s < stall; s++) begin
      wb_stall_i = 1'b1;   // ready left high: must be ignored outside BUSY
      #1;
      chk("done_stall_we", 64'(hilo_we_o), 64'd0);
      chk("done_stall_stallreq", 64'(stallreq_o), 64'd1);
      chk("done_stall_start", 64'(div_start_o), 64'd0);
      @(negedge clk);
    end
    wb_stall_i = 1'b0; div_ready_i = 1'b0;
    if (flush_done) begin
      flush_i = 1'b1;
      #1;
      chk("done_flush_we", 64'(hilo_we_o), 64'd0);
      @(negedge clk);
      flush_i = 1'b0;
      #1;
      check_idle_outputs("done_abort");
      @(negedge clk);
    end else begin
      #1;
      chk("wr_we", 64'(hilo_we_o), 64'd1);
      chk("wr_stallreq", 64'(stallreq_o), 64'd0);
      chk("wr_start", 64'(div_start_o), 64'd0);
      @(negedge clk);
    end
    #1;
    check_idle_outputs("post");
    chk("hi", 64'(hi_o), 64'(exp_hi));
    chk("lo", 64'(lo_o), 64'(exp_lo));
    chk("last_lat", 64'(last_lat_o), 64'(exp_lat));
  endtask

  initial begin
    rst = 1'b1; op_valid_i = 0; op_is_div_i = 0; op_signed_i = 0; op1_i = 0; op2_i = 0;
    flush_i = 0; wb_stall_i = 0; div_result_i = 0; div_ready_i = 0;
    exp_hi = 0; exp_lo = 0; exp_lat = 0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle_outputs("reset");
    chk("reset_hi", 64'(hi_o), 64'd0);
    chk("reset_lo", 64'(lo_o), 64'd0);
    chk("reset_lat", 64'(last_lat_o), 64'd0);
    chk("reset_op1", 64'(div_op1_o), 64'd0);
    chk("reset_op2", 64'(div_op2_o), 64'd0);
    chk("reset_sgn", 64'(div_signed_o), 64'd0);

    // DIV -7 / 2, 34 BUSY cycles
    run_div(1'b1, 32'hFFFFFFF9, 32'h2, 34, 0, 0, 0, 0);
    chk("div_m7_hi", 64'(hi_o), 64'hFFFFFFFF);
    chk("div_m7_lo", 64'(lo_o), 64'hFFFFFFFD);
    chk("div_m7_lat", 64'(last_lat_o), 64'd34);
    // DIVU 0xFFFFFFFF / 0x10
    run_div(1'b0, 32'hFFFFFFFF, 32'h10, 33, 0, 0, 0, 0);
    chk("divu_lo", 64'(lo_o), 64'h0FFFFFFF);
    chk("divu_hi", 64'(hi_o), 64'h0000000F);
    // flush in the 10th BUSY cycle
    run_div(1'b1, 32'd1000, 32'd7, 34, 0, 10, 0, 0);
    // ready with writeback stall for 5 cycles
    run_div(1'b0, 32'd12345, 32'd100, 5, 5, 0, 0, 0);
    // divide by zero, result 0 after 2 cycles, then an immediate second divide
    run_div(1'b0, 32'd55, 32'd0, 2, 0, 0, 0, 1);
    chk("dz_hi", 64'(hi_o), 64'd0);
    chk("dz_lat", 64'(last_lat_o), 64'd2);
    run_div(1'b1, 32'd99, 32'd9, 3, 0, 0, 0, 0);
    // flush while ready in the same BUSY cycle; flush in DONE
    run_div(1'b0, 32'd77, 32'd5, 4, 0, 4, 0, 0);
    run_div(1'b1, 32'd500, 32'hFFFFFFFB, 6, 2, 0, 1, 0);
    // saturation of the latency count
    run_div(1'b0, 32'd9, 32'd4, 70, 0, 0, 0, 0);
    chk("sat_lat", 64'(last_lat_o), 64'd63);

    // reset mid-BUSY
    op_valid_i = 1; op_is_div_i = 1; op_signed_i = 1; op1_i = 32'd8; op2_i = 32'd3;
    @(negedge clk);
    op_valid_i = 0;
    repeat (4) @(negedge clk);
    rst = 1'b1; div_ready_i = 1'b1; div_result_i = 64'hDEAD_BEEF_1234_5678;
    @(negedge clk);
    rst = 1'b0; div_ready_i = 1'b0;
    #1;
    check_idle_outputs("midrst");
    chk("midrst_hi", 64'(hi_o), 64'd0);
    chk("midrst_lo", 64'(lo_o), 64'd0);
    chk("midrst_lat", 64'(last_lat_o), 64'd0);
    chk("midrst_op1", 64'(div_op1_o), 64'd0);
    exp_hi = 0; exp_lo = 0; exp_lat = 0;
    run_div(1'b1, 32'd8, 32'd3, 5, 0, 0, 0, 0);

    // random transactions against the reference model
    for (int n = 0; n < 25; n++) begin
      logic [31:0] a, b;
      int lat, fl;
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
      if (b == 0) b = 1;
      if (a == 32'h80000000) a = 1;
      lat = $urandom_range(1, 40);
      if ($urandom_range(0, 9) == 0) lat = $urandom_range(60, 70);
      fl = ($urandom_range(0, 4) == 0) ? $urandom_range(1, lat) : 0;
      run_div(1'($urandom), a, b, lat, $urandom_range(0, 3), fl,
              ($urandom_range(0, 7) == 0), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
